interleaver_4_4_ctrl: RTL and testbench
=======================================

Name: interleaver_4_4_ctrl

Overview:
Sequencer for the 4x4 byte interleaver core (16 x 8-bit block).
- Accepts a valid/ready byte stream and writes 16 bytes into the core at addresses 0..15 with write_i=1.
- Reads the block back in interleaved order, leaver_i=1, addresses 0..15, and emits it as a valid/ready stream with a last flag.
- Sits between the framing logic upstream and the modulator path downstream; it owns every control pin of the core.

Parameters:
BLK_LEN, 16, bytes per block; fixed by the 4x4 core, address counter is log2(BLK_LEN)=4 bits
DW, 8, data width; must match the core data width
RD_LAT, 1, core read latency in cycles, from addr presented (write_i=0) to data_o valid

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-low reset; rst=0 sampled at a clk edge resets the block
flush_i  in  1  synchronous abort of the current block; effective on the same edge as sampled
in_valid_i  in  1  upstream byte valid
in_ready_o  out  1  upstream ready
in_data_i  in  DW  upstream byte
out_valid_o  out  1  downstream byte valid
out_ready_i  in  1  downstream ready
out_data_o  out  DW  interleaved byte
out_last_o  out  1  high with the 16th output byte of a block
itl_leaver_o  out  1  to core leaver_i
itl_write_o  out  1  to core write_i
itl_addr_o  out  4  to core addr
itl_data_o  out  DW  to core data_i
itl_data_i  in  DW  from core data_o
busy_o  out  1  high in READ or DRAIN
blk_cnt_o  out  16  completed blocks, wraps at 0xFFFF->0

Behaviour:
- Reset (rst=0): state=WRITE, wr_addr=0, rd_addr=0, inflight=0, FIFO empty, blk_cnt=0. All outputs 0 except in_ready_o=1. itl_write_o=0 and itl_leaver_o=0 during reset.
- WRITE state:
  - in_ready_o=1; itl_write_o = in_valid_i; itl_addr_o = wr_addr; itl_data_o = in_data_i (combinational pass-through).
  - Each accepted byte (valid&&ready) increments wr_addr.
  - On accepting the byte at wr_addr=15: wr_addr wraps to 0; next state is READ.
  - No reads are issued; out_valid_o stays 0 unless the FIFO still holds bytes from the previous block.
- READ state:
  - in_ready_o=0; itl_write_o=0; itl_leaver_o=1; itl_addr_o = rd_addr.
  - A read issues on a cycle when (fifo_count - pop + inflight) < 2, where pop = out_valid_o && out_ready_i.
  - A read issue increments rd_addr and sets inflight for RD_LAT cycles.
  - itl_data_i is pushed into a 2-entry output FIFO RD_LAT cycles after its issue; the FIFO entry carries last = (issued rd_addr==15).
  - Sustains 1 byte/cycle when out_ready_i=1.
  - On issuing rd_addr=15: rd_addr wraps to 0; next state is DRAIN.
- DRAIN state:
  - itl_leaver_o=1; no new reads.
  - Waits until inflight=0, then enters WRITE. The FIFO may still hold up to 2 bytes; these drain while the next block is written.
  - The next block's writes never disturb pending reads, because all reads have completed before WRITE is entered.
- out_valid_o = FIFO not empty; out_data_o/out_last_o come from the FIFO head.
- Stall rule: out_data_o and out_last_o hold while out_valid_o && !out_ready_i.
- blk_cnt_o increments on the pop of a byte with out_last_o=1.
- itl_leaver_o is 0 in WRITE and 1 in READ/DRAIN. It is registered so that it changes only on the edge entering READ or WRITE.
- flush_i=1:
  - Same reset as rst, except blk_cnt is kept.
  - The in-flight read is discarded and the FIFO is emptied.
  - In WRITE, a byte offered in the flush cycle is not accepted (in_ready_o forced 0 that cycle).
- rst has priority over flush_i.
- Simultaneous push and pop on the FIFO is legal; count is unchanged.
- Illegal by construction: a push into a full FIFO. The verifier asserts this never occurs.

Decomposition:
- Shared package interleaver_pkg:
  - BLK_LEN, DW, ADDR_W=4, RD_LAT
  - state enum {WRITE, READ, DRAIN}
- One sub-module: itl_out_fifo, a 2-entry DW+1 bit FIFO with push, pop, count, full and empty.
- Controller FSM, address counters and credit logic stay in interleaver_4_4_ctrl.

Test Plan:
- Reset: hold rst=0 for 10 cycles, release -> in_ready_o=1, out_valid_o=0, itl_write_o=0, blk_cnt_o=0.
- Write bytes 0x00..0x0F back-to-back, out_ready_i=1 -> itl_write_o high for exactly 16 cycles with itl_addr_o 0..15. Then 16 outputs equal the core's interleaved order for that block; out_last_o is high on the 16th byte only; blk_cnt_o=1.
- Same block with out_ready_i toggling 1,0,0,1 pattern -> same 16 bytes in the same order, none lost or duplicated, and the data is stable during stalls.
- Three blocks streamed continuously with in_valid_i=1 -> in_ready_o drops during each READ/DRAIN. Outputs are 48 bytes with out_last_o at bytes 16, 32 and 48; blk_cnt_o=3.
- flush_i pulsed after 7 bytes written -> wr_addr restarts at 0; the next 16 bytes form a full block whose output matches an unflushed run.
- rst=0 asserted mid-READ with 2 bytes in the FIFO -> next edge out_valid_o=0 and state=WRITE; blk_cnt_o=0.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared constants and state type for the 4x4 interleaver sequencer.
package interleaver_pkg;
  localparam int BLK_LEN = 16;
  localparam int DW      = 8;
  localparam int ADDR_W  = 4;
  localparam int RD_LAT  = 1;

  typedef enum logic [1:0] {
    WRITE = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/itl_out_fifo.sv
// Two-entry output FIFO carrying {last, data}; head is held until popped.
module itl_out_fifo
  import interleaver_pkg::*;
#(
  parameter int W = DW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/interleaver_4_4_ctrl.sv
// Sequencer for the 4x4 byte interleaver core: writes a 16-byte block,
// reads it back in interleaved order and streams it out with a last flag.
module interleaver_4_4_ctrl
  import interleaver_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          itl_leaver_o,
  output logic          itl_write_o,
  output logic [3:0]    itl_addr_o,
  output logic [DW-1:0] itl_data_o,
  input  logic [DW-1:0] itl_data_i,
  output logic          busy_o,
  output logic [15:0]   blk_cnt_o
);
  // state | meaning
  // WRITE | accept 16 bytes into the core, addresses 0..15
  // READ  | issue interleaved reads under FIFO credit
  // DRAIN | all reads issued, wait for the last one to return

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLK_LEN - 1);

  state_t              state;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [RD_LAT-1:0]   infl_vld;
  logic [RD_LAT-1:0]   infl_last;
  logic                leaver_q;
  logic [15:0]         blk_cnt;

  logic                is_wr;
  logic                accept;
  logic                issue;
  logic                pop;
  logic                push;
  logic [3:0]          infl_n;
  logic [3:0]          credit_sum;
  logic [DW:0]         fifo_dout;
  logic [1:0]          fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  assign is_wr  = (state == WRITE);
  assign accept = is_wr && in_valid_i && !flush_i && rst;
  assign pop    = !fifo_empty && out_ready_i;
  // A push into a full FIFO cannot happen under the credit rule; the guard
  // only keeps a stale head from being overwritten if it ever did.
  assign push   = infl_vld[RD_LAT-1] && !fifo_full;

  always_comb begin
    infl_n = '0;
    for (int i = 0; i < RD_LAT; i++) infl_n = infl_n + {3'd0, infl_vld[i]};
  end

  // Bytes the FIFO will hold once everything in flight lands.
  assign credit_sum = {2'd0, fifo_count} + infl_n - {3'd0, pop};
  assign issue      = (state == READ) && (credit_sum < 4'd2) && !flush_i && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WRITE;
      wr_addr   <= '0;
      rd_addr   <= '0;
      infl_vld  <= '0;
      infl_last <= '0;
      leaver_q  <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      if (pop && fifo_dout[DW]) blk_cnt <= blk_cnt + 16'd1;
      if (flush_i) begin
        state     <= WRITE;
        wr_addr   <= '0;
        rd_addr   <= '0;
        infl_vld  <= '0;
        infl_last <= '0;
        leaver_q  <= 1'b0;
      end else begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
          infl_vld[i]  <= infl_vld[i-1];
          infl_last[i] <= infl_last[i-1];
        end
        infl_vld[0]  <= issue;
        infl_last[0] <= issue && (rd_addr == LAST_ADDR);
        case (state)
          WRITE: if (accept) begin
            wr_addr <= wr_addr + 1'b1;
            if (wr_addr == LAST_ADDR) begin
              state    <= READ;
              leaver_q <= 1'b1;
            end
          end
          READ: if (issue) begin
            rd_addr <= rd_addr + 1'b1;
            if (rd_addr == LAST_ADDR) state <= DRAIN;
          end
          DRAIN: if (infl_n == 4'd0) begin
            state    <= WRITE;
            leaver_q <= 1'b0;
          end
          default: begin
            state    <= WRITE;
            leaver_q <= 1'b0;
          end
        endcase
      end
    end
  end

  itl_out_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_i),
    .push  (push),
    .pop   (pop),
    .din   ({infl_last[RD_LAT-1], itl_data_i}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready_o   = is_wr && !(flush_i && rst);
  assign itl_write_o  = accept;
  assign itl_addr_o   = is_wr ? wr_addr : rd_addr;
  assign itl_data_o   = is_wr ? in_data_i : '0;
  assign itl_leaver_o = leaver_q;
  assign out_valid_o  = !fifo_empty;
  assign out_data_o   = fifo_dout[DW-1:0];
  assign out_last_o   = fifo_dout[DW];
  assign busy_o       = !is_wr;
  assign blk_cnt_o    = blk_cnt;
endmodule

// File: tb/tb_interleaver_4_4_ctrl.sv
// Self-checking bench: behavioural core model plus a block-level reference.
module tb_interleaver_4_4_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  in_data_i = 8'h00;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic        itl_leaver_o;
  logic        itl_write_o;
  logic [3:0]  itl_addr_o;
  logic [7:0]  itl_data_o;
  logic [7:0]  itl_data_i;
  logic        busy_o;
  logic [15:0] blk_cnt_o;

  interleaver_4_4_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .itl_leaver_o (itl_leaver_o),
    .itl_write_o  (itl_write_o),
    .itl_addr_o   (itl_addr_o),
    .itl_data_o   (itl_data_o),
    .itl_data_i   (itl_data_i),
    .busy_o       (busy_o),
    .blk_cnt_o    (blk_cnt_o)
  );

  always #5 clk = ~clk;

  // Core model: row-wise writes, column-wise interleaved reads, 1-cycle latency.
  logic [7:0] core_mem [16];
  logic [7:0] core_q = 8'h00;
  assign itl_data_i = core_q;
  always @(posedge clk) begin
    if (itl_write_o) core_mem[itl_addr_o] <= itl_data_o;
    core_q <= core_mem[itl_leaver_o ? {itl_addr_o[1:0], itl_addr_o[3:2]} : itl_addr_o];
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] part_q[$];
  int blocks_done = 0;
  int wr_seen = 0;
  int ready_falls = 0;
  int rdy_mode = 0;
  bit mon_en = 0;
  bit prev_rdy = 1;
  bit prev_stall = 0;
  logic [8:0] prev_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: reference model of accepted blocks and checks on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst) begin
        part_q.delete();
        prev_stall = 0;
      end else begin
        if (flush_i) chk("flush_ready", in_ready_o, 0);
        if (in_valid_i && in_ready_o && !flush_i) begin
          chk("wr_strobe", itl_write_o, 1);
          chk("wr_addr", itl_addr_o, part_q.size());
          chk("wr_data", itl_data_o, in_data_i);
          part_q.push_back(in_data_i);
          if (part_q.size() == 16) begin
            for (int k = 0; k < 16; k++)
              exp_q.push_back({k == 15, part_q[(k % 4) * 4 + k / 4]});
            blocks_done++;
            part_q.delete();
          end
        end else begin
          chk("no_write", itl_write_o, 0);
        end
        if (itl_write_o) wr_seen++;
        if (flush_i) part_q.delete();
        if (prev_stall) begin
          chk("stall_valid", out_valid_o, 1);
          chk("stall_hold", {out_last_o, out_data_o}, prev_out);
        end
        if (out_valid_o && out_ready_i) got_q.push_back({out_last_o, out_data_o});
        chk("leaver_busy", itl_leaver_o, busy_o);
        if (dut.infl_vld[0]) chk("push_full", dut.fifo_full, 0);
        if (prev_rdy && !in_ready_o) ready_falls++;
        prev_rdy   = in_ready_o;
        prev_stall = out_valid_o && !out_ready_i && !flush_i;
        prev_out   = {out_last_o, out_data_o};
      end
    end
  end

  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (rdy_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ((k % 4) == 0) || ((k % 4) == 3);
        2:       out_ready_i = 1'($urandom_range(0, 1));
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data_i  = b;
    in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", in_ready_o, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_n(input int n, input bit rnd);
    for (int i = 0; i < n; i++) send_byte(rnd ? 8'($urandom) : 8'(i));
    in_valid_i = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_data"}, got_q[i][7:0], exp_q[i][7:0]);
      chk({tag, "_last"}, got_q[i][8], exp_q[i][8]);
    end
    chk({tag, "_idle"}, out_valid_o, 0);
    chk({tag, "_blk"}, blk_cnt_o, blocks_done);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_write", itl_write_o, 0);
    chk("rst_leaver", itl_leaver_o, 0);
    chk("rst_blk", blk_cnt_o, 0);
    rst    = 1'b1;
    mon_en = 1;

    // Ascending block, downstream always ready.
    rdy_mode = 0;
    wr_seen  = 0;
    send_n(16, 0);
    chk("t2_writes", wr_seen, 16);
    drain_and_check("t2");

    // Same block with 1,0,0,1 backpressure.
    rdy_mode = 1;
    send_n(16, 0);
    drain_and_check("t3");

    // Three random blocks streamed back to back.
    rdy_mode    = 0;
    ready_falls = 0;
    send_n(48, 1);
    drain_and_check("t4");
    chk("t4_ready_falls", ready_falls, 3);

    // Flush after 7 bytes, with a byte offered in the flush cycle.
    rdy_mode = 2;
    send_n(7, 1);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'hA5;
    @(posedge clk);
    #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("t5_addr_restart", itl_addr_o, 0);
    send_n(16, 1);
    drain_and_check("t5");

    // Reset in the middle of READ with the FIFO holding two bytes.
    rdy_mode = 3;
    send_n(16, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_busy", busy_o, 1);
    chk("t6_fifo_valid", out_valid_o, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_out_valid", out_valid_o, 0);
    chk("t6_busy_after", busy_o, 0);
    chk("t6_blk", blk_cnt_o, 0);
    chk("t6_in_ready", in_ready_o, 1);
    exp_q.delete();
    got_q.delete();
    blocks_done = 0;
    rst = 1'b1;

    // Recovery block with random backpressure.
    rdy_mode = 2;
    send_n(16, 1);
    drain_and_check("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
